// File: rtl/alu_operand_sequencer.sv
// Mini ALU front end: serially collects A, B and opcode, then captures the unit result with valid/ready.
// Optional macro ALU_LOAD_EDGE_EN makes load rising-edge sensitive instead of level sensitive.
module alu_operand_sequencer #(
  parameter int W     = 6,
  parameter int OPW   = 3,
  parameter int N_OPS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           load,
  input  logic           clear,
  output logic [W-1:0]   x1,
  output logic [W-1:0]   y1,
  output logic [OPW-1:0] op_sel,
  input  logic [W-1:0]   c_in,
  output logic [W-1:0]   result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           err,
  output logic           busy,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;
  logic   load_go;

`ifdef ALU_LOAD_EDGE_EN
  logic load_d;

  // load_d follows load in every state, so a held strobe advances only once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_d <= 1'b0;
    else        load_d <= load;
  end

  assign load_go = load & ~load_d;
`else
  assign load_go = load;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_A;
      x1        <= '0;
      y1        <= '0;
      op_sel    <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else if (clear) begin
      state     <= S_A;
      x1        <= '0;
      y1        <= '0;
      op_sel    <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        S_A: if (load_go) begin
          x1    <= din;
          state <= S_B;
        end
        S_B: if (load_go) begin
          y1    <= din;
          state <= S_OP;
        end
        S_OP: if (load_go) begin
          op_sel <= din[OPW-1:0];
          state  <= S_EXEC;
        end
        // Opcodes past the implemented units yield a zero result flagged by err
        S_EXEC: begin
          if (int'(op_sel) < N_OPS) begin
            result <= c_in;
            err    <= 1'b0;
          end else begin
            result <= '0;
            err    <= 1'b1;
          end
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          err       <= 1'b0;
          state     <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end

  assign busy      = (state == S_EXEC) || (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed vector table, corner sequences and a
// randomized run against a behavioural model. Follows ALU_LOAD_EDGE_EN if it is defined.
module tb_alu_operand_sequencer;

`ifdef ALU_LOAD_EDGE_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif
  localparam int NOPS = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] din = '0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] x1, y1, result;
  logic [2:0] op_sel, state_dbg;
  logic [5:0] c_in = '0;
  logic       out_valid, out_ready = 1'b0, err, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_operand_sequencer #(.W(6), .OPW(3), .N_OPS(NOPS)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load), .clear(clear),
    .x1(x1), .y1(y1), .op_sel(op_sel), .c_in(c_in), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .err(err), .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       ld, clr, rdy;
    bit [5:0] d, cin;
    int       st;
    bit [5:0] ex, ey, eres;
    bit [2:0] eop;
    bit       ev, eerr;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: stage counts entries taken (0..2), 3 = executing, 4 = awaiting ready
  int       m_stage;
  bit [5:0] m_x, m_y, m_res;
  bit [2:0] m_op;
  bit       m_v, m_err, m_prev;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag, input int st, input bit [5:0] ex, input bit [5:0] ey,
                              input bit [2:0] eop, input bit [5:0] eres, input bit ev, input bit eerr);
    check({tag, ".state"}, int'(state_dbg), st);
    check({tag, ".x1"}, int'(x1), int'(ex));
    check({tag, ".y1"}, int'(y1), int'(ey));
    check({tag, ".op_sel"}, int'(op_sel), int'(eop));
    check({tag, ".result"}, int'(result), int'(eres));
    check({tag, ".out_valid"}, int'(out_valid), int'(ev));
    check({tag, ".err"}, int'(err), int'(eerr));
    check({tag, ".busy"}, int'(busy), (st >= 3) ? 1 : 0);
  endtask

  // Inputs change on the falling edge; the DUT samples them on the following rising edge
  task automatic apply_stimulus(input bit ld, input bit clr, input bit rdy, input bit [5:0] d,
                                input bit [5:0] cin);
    load = ld; clear = clr; out_ready = rdy; din = d; c_in = cin;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; load = 0; clear = 0; out_ready = 0; din = '0; c_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input bit ld, input bit clr, input bit rdy, input bit [5:0] d, input bit [5:0] cin,
                         input int st, input bit [5:0] ex, input bit [5:0] ey, input bit [2:0] eop,
                         input bit [5:0] eres, input bit ev, input bit eerr);
    vec_t v;
    v.ld = ld; v.clr = clr; v.rdy = rdy; v.d = d; v.cin = cin; v.st = st;
    v.ex = ex; v.ey = ey; v.eop = eop; v.eres = eres; v.ev = ev; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    m_stage = 0; m_x = 0; m_y = 0; m_op = 0; m_res = 0; m_v = 0; m_err = 0; m_prev = 0;
  endtask

  task automatic model_edge(input bit ld, input bit clr, input bit rdy, input bit [5:0] d, input bit [5:0] cin);
    bit take;
    take   = EDGE_MODE ? (ld && !m_prev) : ld;
    m_prev = ld;
    if (clr) begin
      m_stage = 0; m_x = 0; m_y = 0; m_op = 0; m_res = 0; m_v = 0; m_err = 0;
    end else if (m_stage == 0 && take) begin
      m_x = d; m_stage = 1;
    end else if (m_stage == 1 && take) begin
      m_y = d; m_stage = 2;
    end else if (m_stage == 2 && take) begin
      m_op = d[2:0]; m_stage = 3;
    end else if (m_stage == 3) begin
      m_err = (int'(m_op) >= NOPS);
      m_res = m_err ? 6'd0 : cin;
      m_v = 1; m_stage = 4;
    end else if (m_stage == 4 && rdy) begin
      m_v = 0; m_err = 0; m_stage = 0;
    end
  endtask

  initial begin
    // ld clr rdy din cin | state x1 y1 op result valid err
    add_vec(1,0,0,21, 0, 1,21, 0,0, 0,0,0);
    add_vec(0,0,0, 0, 0, 1,21, 0,0, 0,0,0);
    add_vec(1,0,0, 9, 0, 2,21, 9,0, 0,0,0);
    add_vec(0,0,0, 0, 0, 2,21, 9,0, 0,0,0);
    add_vec(1,0,0, 2, 0, 3,21, 9,2, 0,0,0);
    add_vec(0,0,0, 0,30, 4,21, 9,2,30,1,0);
    add_vec(1,0,0, 7,11, 4,21, 9,2,30,1,0);
    add_vec(0,0,0, 7,11, 4,21, 9,2,30,1,0);
    add_vec(1,0,0, 7,11, 4,21, 9,2,30,1,0);
    add_vec(0,0,0, 7,11, 4,21, 9,2,30,1,0);
    add_vec(1,0,0, 7,11, 4,21, 9,2,30,1,0);
    add_vec(0,0,1, 0, 0, 0,21, 9,2,30,0,0);
    add_vec(1,0,0, 4, 0, 1, 4, 9,2,30,0,0);
    add_vec(0,0,0, 0, 0, 1, 4, 9,2,30,0,0);
    add_vec(1,0,0,63, 0, 2, 4,63,2,30,0,0);
    add_vec(0,0,0, 0, 0, 2, 4,63,2,30,0,0);
    add_vec(1,0,0, 7, 0, 3, 4,63,7,30,0,0);
    add_vec(0,0,0, 0,45, 4, 4,63,7, 0,1,1);
    add_vec(0,0,1, 0, 0, 0, 4,63,7, 0,0,0);
    add_vec(1,0,0,10, 0, 1,10,63,7, 0,0,0);
    add_vec(0,0,0, 0, 0, 1,10,63,7, 0,0,0);
    add_vec(1,0,0,20, 0, 2,10,20,7, 0,0,0);
    add_vec(0,0,0, 0, 0, 2,10,20,7, 0,0,0);
    add_vec(1,0,0,45, 0, 3,10,20,5, 0,0,0);
    add_vec(0,0,1, 0,33, 4,10,20,5,33,1,0);
    add_vec(1,0,1,17, 0, 0,10,20,5,33,0,0);
    add_vec(0,0,0, 0, 0, 0,10,20,5,33,0,0);
    add_vec(1,0,0, 5, 0, 1, 5,20,5,33,0,0);
    add_vec(0,0,0, 0, 0, 1, 5,20,5,33,0,0);
    add_vec(1,0,0, 3, 0, 2, 5, 3,5,33,0,0);
    add_vec(0,1,0, 0, 0, 0, 0, 0,0, 0,0,0);
    add_vec(1,0,0, 1, 0, 1, 1, 0,0, 0,0,0);
    add_vec(0,0,0, 0, 0, 1, 1, 0,0, 0,0,0);
    add_vec(1,0,0, 2, 0, 2, 1, 2,0, 0,0,0);
    add_vec(0,0,0, 0, 0, 2, 1, 2,0, 0,0,0);
    add_vec(1,0,0, 3, 0, 3, 1, 2,3, 0,0,0);
    add_vec(0,0,0, 0,50, 4, 1, 2,3,50,1,0);
    add_vec(1,1,1, 9, 0, 0, 0, 0,0, 0,0,0);
    add_vec(0,0,0, 0, 0, 0, 0, 0,0, 0,0,0);

    do_reset();
    @(negedge clk);
    check_output("reset", 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].ld, vecs[i].clr, vecs[i].rdy, vecs[i].d, vecs[i].cin);
      check_output($sformatf("vec%0d", i), vecs[i].st, vecs[i].ex, vecs[i].ey, vecs[i].eop,
                   vecs[i].eres, vecs[i].ev, vecs[i].eerr);
    end

    // Asynchronous reset in the middle of S_B clears everything without a clock edge
    do_reset();
    @(negedge clk);
    apply_stimulus(1, 0, 0, 6'd42, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check("areset.pre_state", int'(state_dbg), 1);
    #2 rst_n = 1'b0;
    #1 check_output("areset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1, 0, 0, 6'd8, 0);
    check_output("areset.restart", 1, 8, 0, 0, 0, 0, 0);

    // Held load from S_A: level mode walks A, B, op; edge mode captures A only
    do_reset();
    @(negedge clk);
    apply_stimulus(1, 0, 0, 6'd11, 0);
    apply_stimulus(1, 0, 0, 6'd12, 0);
    apply_stimulus(1, 0, 0, 6'd13, 0);
    if (EDGE_MODE) check_output("held_load", 1, 11, 0, 0, 0, 0, 0);
    else           check_output("held_load", 3, 11, 12, 5, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);

    // Randomized run against the model
    do_reset();
    model_reset();
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      bit       r_ld, r_clr, r_rdy;
      bit [5:0] r_d, r_c;
      r_ld  = ($urandom_range(0, 1) == 1);
      r_clr = ($urandom_range(0, 24) == 0);
      r_rdy = ($urandom_range(0, 2) == 0);
      r_d   = 6'($urandom_range(0, 63));
      r_c   = 6'($urandom_range(0, 63));
      apply_stimulus(r_ld, r_clr, r_rdy, r_d, r_c);
      model_edge(r_ld, r_clr, r_rdy, r_d, r_c);
      check_output($sformatf("rand%0d", n), m_stage, m_x, m_y, m_op, m_res, m_v, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
